// File: rtl/truth_table_checker.sv
// Response monitor for 2-input gate DUTs: waits for {a,b} to settle, samples c against TRUTH,
// and accumulates errors and coverage. Optional watchdog enabled by defining CHK_TIMEOUT_EN.
module truth_table_checker #(
   parameter logic [3:0] TRUTH   = 4'b1000,
   parameter int         SETTLE  = 2,
   parameter int         CNT_W   = 8,
   parameter int         TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt,
   output logic [3:0]       cov,
   output logic             timeout
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD, ST_DONE} state_t;

   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [CNT_W-1:0] ERR_MAX     = '1;

   if (SETTLE < 1 || SETTLE > 255 || TIMEOUT < 1) begin : g_bad_param
      $error("truth_table_checker: SETTLE must be 1..255 and TIMEOUT >= 1");
   end

   state_t           state;
   logic [7:0]       cnt;
   logic [1:0]       prev;
   logic [1:0]       ab;
   logic             sample_now;
   logic             sample_bad;
   logic [3:0]       cov_next;
   logic [CNT_W-1:0] err_next;
   logic             wd_hit;

   assign ab = {a, b};

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      sample_now = (state == ST_SETTLE) && (ab == prev) && (cnt == SETTLE_LAST);
      sample_bad = sample_now && (c != TRUTH[prev]);
      cov_next   = cov;
      err_next   = err_cnt;
      if (sample_now) cov_next[prev] = 1'b1;
      if (sample_bad && err_cnt != ERR_MAX) err_next = err_cnt + CNT_W'(1);
   end

`ifdef CHK_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            timeout_q;

   // Counts busy cycles since the last start; the hit fires on the edge ending the TIMEOUT-th one.
   assign wd_hit  = busy && (wd_cnt == WD_W'(TIMEOUT - 1));
   assign timeout = timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else if (start) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else if (wd_hit) begin
         timeout_q <= 1'b1;
      end else if (busy) begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end
   end
`else
   assign wd_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         mismatch <= 1'b0;
         err_cnt  <= '0;
         cov      <= '0;
         cnt      <= '0;
         prev     <= '0;
      end else begin
         mismatch <= 1'b0;
         if (start) begin
            state   <= ST_SETTLE;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            cov     <= '0;
            prev    <= ab;
            cnt     <= '0;
         end else begin
            case (state)
               ST_SETTLE: begin
                  if (ab != prev) begin
                     prev <= ab;
                     cnt  <= '0;
                  end else if (sample_now) begin
                     cov      <= cov_next;
                     err_cnt  <= err_next;
                     mismatch <= sample_bad;
                     if (cov_next == 4'hF) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                     end else begin
                        state <= ST_HOLD;
                     end
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               ST_HOLD: begin
                  if (ab != prev) begin
                     prev  <= ab;
                     cnt   <= '0;
                     state <= ST_SETTLE;
                  end
               end
               default: ;
            endcase
            // A watchdog expiry overrides whatever the sample decided on this edge.
            if (wd_hit) begin
               state <= ST_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: vector table, hand-written corner sequences,
// and randomized traffic compared against a run-length based reference model.
module tb_truth_table_checker;

   localparam int SETTLE = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic a = 1'b0;
   logic b = 1'b0;
   logic c = 1'b0;
   logic c_sat;

   logic       m_busy, m_done, m_pass, m_mis, m_to;
   logic [7:0] m_err;
   logic [3:0] m_cov;
   logic       s_busy, s_done, s_pass, s_mis, s_to;
   logic [1:0] s_err;
   logic [3:0] s_cov;
   logic       w_busy, w_done, w_pass, w_mis, w_to;
   logic [7:0] w_err;
   logic [3:0] w_cov;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign c_sat = ~(a & b);

   truth_table_checker #(.TRUTH(4'b1000), .SETTLE(SETTLE), .CNT_W(8), .TIMEOUT(1000)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
      .busy(m_busy), .done(m_done), .pass(m_pass), .mismatch(m_mis),
      .err_cnt(m_err), .cov(m_cov), .timeout(m_to));

   truth_table_checker #(.TRUTH(4'b1000), .SETTLE(SETTLE), .CNT_W(2), .TIMEOUT(1000)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c_sat),
      .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mis),
      .err_cnt(s_err), .cov(s_cov), .timeout(s_to));

   truth_table_checker #(.TRUTH(4'b1000), .SETTLE(SETTLE), .CNT_W(8), .TIMEOUT(50)) dut_wd (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(a & b),
      .busy(w_busy), .done(w_done), .pass(w_pass), .mismatch(w_mis),
      .err_cnt(w_err), .cov(w_cov), .timeout(w_to));

   // Reference model: a combination is sampled once it has been seen on SETTLE+1 consecutive
   // edges since tracking (re)armed, i.e. since start or since {a,b} last changed.
   typedef struct {
      bit       running;
      bit       armed;
      int       streak;
      bit [1:0] last;
      bit [3:0] cov;
      int       errs;
      bit       mis;
      bit       done;
   } model_t;

   typedef struct {
      bit       st;
      bit [1:0] ab;
      bit       c;
      bit [3:0] flags;  // {busy, done, pass, mismatch}
      bit [3:0] cov;
      bit [7:0] err;
   } vec_t;

   model_t mm, ms;
   vec_t   vecs[$];

   function automatic model_t model_step(model_t m, bit st, bit [1:0] ab, bit cv);
      m.mis = 1'b0;
      if (st) begin
         m.running = 1'b1;
         m.armed   = 1'b1;
         m.streak  = 1;
         m.last    = ab;
         m.cov     = 4'h0;
         m.errs    = 0;
         m.done    = 1'b0;
      end else if (m.running && !m.done) begin
         if (ab != m.last) begin
            m.last   = ab;
            m.streak = 1;
            m.armed  = 1'b1;
         end else begin
            m.streak++;
         end
         if (m.armed && m.streak == SETTLE + 1) begin
            m.armed   = 1'b0;
            m.cov[ab] = 1'b1;
            // AND gate: expected c is 1 only for {1,1}.
            if (cv != (ab == 2'b11)) begin
               m.errs++;
               m.mis = 1'b1;
            end
            if (m.cov == 4'hF) m.done = 1'b1;
         end
      end
      return m;
   endfunction

   function automatic logic [15:0] expect_of(model_t m, int w);
      int maxe;
      int e;
      maxe = (1 << w) - 1;
      e    = (m.errs > maxe) ? maxe : m.errs;
      return {m.running && !m.done, m.done, m.done && m.errs == 0, m.mis, m.cov, 8'(e)};
   endfunction

   function automatic vec_t mk(bit st, bit [1:0] ab, bit cv, bit [3:0] flags, bit [3:0] cv4,
                               bit [7:0] err);
      vec_t v;
      v.st = st; v.ab = ab; v.c = cv; v.flags = flags; v.cov = cv4; v.err = err;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
      end
   endtask

   function automatic logic [15:0] got_main();
      return {m_busy, m_done, m_pass, m_mis, m_cov, m_err};
   endfunction

   function automatic logic [15:0] got_sat();
      return {s_busy, s_done, s_pass, s_mis, s_cov, 6'b0, s_err};
   endfunction

   // Drives one cycle of stimulus, waits past the edge, and advances both models.
   task automatic apply(input bit st, input bit [1:0] ab, input bit cv);
      start = st; a = ab[1]; b = ab[0]; c = cv;
      @(posedge clk); #1;
      mm = model_step(mm, st, ab, cv);
      ms = model_step(ms, st, ab, ~(ab[1] & ab[0]));
   endtask

   task automatic step(input bit st, input bit [1:0] ab, input bit cv, input string nm);
      apply(st, ab, cv);
      check({nm, "_main"}, 32'(got_main()), 32'(expect_of(mm, 8)));
      check({nm, "_sat"}, 32'(got_sat()), 32'(expect_of(ms, 2)));
      check({nm, "_to"}, 32'({m_to, s_to}), 32'(0));
   endtask

   task automatic hold(input bit [1:0] ab, input bit cv, input int n, input string nm);
      for (int i = 0; i < n; i++) step(1'b0, ab, cv, nm);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit reached: got=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      mm = '{default: 0};
      ms = '{default: 0};

      // Test 1 (correct AND) followed by test 2 (c stuck at 0), one row per clock edge.
      vecs.push_back(mk(1, 2'b00, 0, 4'b1000, 4'b0000, 0));
      vecs.push_back(mk(0, 2'b00, 0, 4'b1000, 4'b0000, 0));
      vecs.push_back(mk(0, 2'b00, 0, 4'b1000, 4'b0001, 0));
      vecs.push_back(mk(0, 2'b01, 0, 4'b1000, 4'b0001, 0));
      vecs.push_back(mk(0, 2'b01, 0, 4'b1000, 4'b0001, 0));
      vecs.push_back(mk(0, 2'b01, 0, 4'b1000, 4'b0011, 0));
      vecs.push_back(mk(0, 2'b10, 0, 4'b1000, 4'b0011, 0));
      vecs.push_back(mk(0, 2'b10, 0, 4'b1000, 4'b0011, 0));
      vecs.push_back(mk(0, 2'b10, 0, 4'b1000, 4'b0111, 0));
      vecs.push_back(mk(0, 2'b11, 1, 4'b1000, 4'b0111, 0));
      vecs.push_back(mk(0, 2'b11, 1, 4'b1000, 4'b0111, 0));
      vecs.push_back(mk(0, 2'b11, 1, 4'b0110, 4'b1111, 0));
      vecs.push_back(mk(0, 2'b00, 0, 4'b0110, 4'b1111, 0));
      vecs.push_back(mk(1, 2'b00, 0, 4'b1000, 4'b0000, 0));
      vecs.push_back(mk(0, 2'b00, 0, 4'b1000, 4'b0000, 0));
      vecs.push_back(mk(0, 2'b00, 0, 4'b1000, 4'b0001, 0));
      vecs.push_back(mk(0, 2'b01, 0, 4'b1000, 4'b0001, 0));
      vecs.push_back(mk(0, 2'b01, 0, 4'b1000, 4'b0001, 0));
      vecs.push_back(mk(0, 2'b01, 0, 4'b1000, 4'b0011, 0));
      vecs.push_back(mk(0, 2'b10, 0, 4'b1000, 4'b0011, 0));
      vecs.push_back(mk(0, 2'b10, 0, 4'b1000, 4'b0011, 0));
      vecs.push_back(mk(0, 2'b10, 0, 4'b1000, 4'b0111, 0));
      vecs.push_back(mk(0, 2'b11, 0, 4'b1000, 4'b0111, 0));
      vecs.push_back(mk(0, 2'b11, 0, 4'b1000, 4'b0111, 0));
      vecs.push_back(mk(0, 2'b11, 0, 4'b0101, 4'b1111, 1));
      vecs.push_back(mk(0, 2'b00, 0, 4'b0100, 4'b1111, 1));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_main", 32'({got_main(), m_to}), 32'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_after_reset", 32'(got_main()), 32'(0));

      foreach (vecs[i]) begin
         apply(vecs[i].st, vecs[i].ab, vecs[i].c);
         check($sformatf("vec%0d", i), 32'(got_main()),
               32'({vecs[i].flags, vecs[i].cov, vecs[i].err}));
      end

      // Test 3: a one-cycle pulse on a is never sampled.
      step(1'b1, 2'b00, 1'b0, "pulse");
      hold(2'b00, 1'b0, 2, "pulse");
      step(1'b0, 2'b10, 1'b0, "pulse");
      hold(2'b00, 1'b0, 4, "pulse");
      check("pulse_cov2", 32'(m_cov[2]), 32'(0));
      check("pulse_cov", 32'(m_cov), 32'(4'b0001));

      // Test 4: inverted c on a 2-bit counter, with re-sampled repeats; must stick at 3.
      step(1'b1, 2'b00, 1'b0, "sat");
      hold(2'b00, 1'b0, 2, "sat");
      hold(2'b01, 1'b0, 3, "sat");
      hold(2'b00, 1'b0, 3, "sat");
      hold(2'b01, 1'b0, 3, "sat");
      hold(2'b10, 1'b0, 3, "sat");
      hold(2'b11, 1'b1, 3, "sat");
      check("sat_err", 32'({s_done, s_pass, s_err}), 32'({1'b1, 1'b0, 2'd3}));

      // Test 5: asynchronous reset mid-SETTLE, then a clean run.
      step(1'b1, 2'b00, 1'b0, "rst");
      hold(2'b00, 1'b0, 2, "rst");
      hold(2'b01, 1'b0, 3, "rst");
      step(1'b0, 2'b10, 1'b0, "rst");
      rst_n = 1'b0;
      #1;
      check("async_rst_main", 32'({got_main(), m_to}), 32'(0));
      check("async_rst_sat", 32'(got_sat()), 32'(0));
      mm = '{default: 0};
      ms = '{default: 0};
      #2 rst_n = 1'b1;
      step(1'b1, 2'b00, 1'b0, "clean");
      hold(2'b00, 1'b0, 4, "clean");
      hold(2'b01, 1'b0, 5, "clean");
      hold(2'b10, 1'b0, 5, "clean");
      hold(2'b11, 1'b1, 5, "clean");
      check("clean_pass", 32'({m_done, m_pass, m_cov, m_err}), 32'({2'b11, 4'hF, 8'd0}));

      // Randomized traffic against the model, with periodic restarts.
      begin
         int       since;
         bit [1:0] ab;
         bit       st;
         bit       cv;
         since = 1000;
         ab    = 2'b00;
         for (int i = 0; i < 600; i++) begin
            st = (since > 120) || ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) ab = 2'($urandom_range(0, 3));
            cv = (ab == 2'b11);
            if ($urandom_range(0, 7) == 0) cv = ~cv;
            step(st, ab, cv, "rand");
            since = st ? 0 : since + 1;
         end
      end

      // Test 6: only 00 and 01 are driven, so full coverage never arrives.
      step(1'b1, 2'b00, 1'b0, "wd");
      for (int k = 1; k <= 60; k++) begin
         step(1'b0, ((k / 4) % 2 == 1) ? 2'b01 : 2'b00, 1'b0, "wd");
`ifdef CHK_TIMEOUT_EN
         check($sformatf("wd_flags_k%0d", k), 32'({w_to, w_done, w_busy}),
               32'((k >= 50) ? 3'b110 : 3'b001));
         if (k == 50)
            check("wd_at_50", 32'({w_pass, w_cov}), 32'({1'b0, 4'b0011}));
`else
         check($sformatf("wd_flags_k%0d", k), 32'({w_to, w_done, w_busy}), 32'(3'b001));
         if (k == 60)
            check("wd_cov", 32'(w_cov), 32'(4'b0011));
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Self-checking response monitor for 2-input gate DUTs. It is the receiving end of the gate stimulus drivers.
- Observes the DUT inputs `a`, `b` and output `c`, waits for the inputs to settle, samples `c` and compares it against a parameterised truth table.
- Accumulates the mismatch count and input-combination coverage, then reports pass/fail once all four combinations have been checked.
- Instantiated alongside gate DUTs (e.g. AND-from-NOR) so benches and on-board tests are self-checking.

Parameters:
- TRUTH, 4'b1000, expected `c` per index {a,b}: bit[{a,b}] = expected value (4'b1000 = AND, 4'b0001 = NOR).
- SETTLE, 2, consecutive stable cycles of {a,b} required before sampling `c`; legal range 1..255.
- CNT_W, 8, width of the error counter.
- TIMEOUT, 1000, cycle limit for the optional watchdog; ignored unless CHK_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; clears results and begins or restarts checking
- a  input  1  DUT input a (observed only)
- b  input  1  DUT input b (observed only)
- c  input  1  DUT output under check
- busy  output  1  high in SETTLE and HOLD
- done  output  1  high in DONE; held until start or reset
- pass  output  1  valid when done=1; 1 iff err_cnt==0 and no timeout
- mismatch  output  1  one-cycle pulse the cycle after a failing sample
- err_cnt  output  CNT_W  saturating count of failing samples
- cov  output  4  coverage; bit[{a,b}] is set once that combination has been sampled
- timeout  output  1  sticky watchdog flag; constant 0 without CHK_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, done, pass, mismatch, timeout=0; err_cnt=0; cov=0; settle counter=0; prev=0.
- FSM states are IDLE, SETTLE, HOLD, DONE.
- Start: start=1 in any state clears err_cnt, cov, mismatch, timeout and done, latches prev<={a,b}, sets cnt<=0 and goes to SETTLE. A mid-run restart discards all results.
- SETTLE, per cycle:
  - If {a,b}!=prev: prev<={a,b}, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - When cnt==SETTLE-1 with {a,b}==prev, sample on that edge:
    - compare c with TRUTH[prev];
    - set cov[prev];
    - on mismatch, err_cnt<=err_cnt+1 (saturating at all ones) and mismatch=1 on the next cycle.
  - With inputs stable from the start edge, the sample occurs at the SETTLE-th rising edge after start.
- After a sample: if cov (including the new bit) ==4'hF, go to DONE; otherwise go to HOLD.
- HOLD: no sampling. When {a,b}!=prev: prev<={a,b}, cnt<=0, go to SETTLE.
- Input pulses shorter than SETTLE cycles are never sampled.
- A combination that reappears is re-sampled and can add errors; its cov bit is already set.
- DONE: done=1, busy=0, pass=(err_cnt==0 && !timeout). Inputs are ignored until start.
- IDLE: inputs ignored; all outputs hold their reset values.
- Simultaneous events:
  - start wins over a sample or input change in the same cycle.
  - A change of `c` alone never restarts settling; only {a,b} are tracked.

Optional Feature:
- Macro: CHK_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while busy=1 and is cleared by start.
  - On reaching TIMEOUT, set timeout=1 and go to DONE with pass=0, whatever the coverage.
  - timeout is cleared only by start or reset.
- Not defined: no watchdog logic; timeout tied to 0; the block waits indefinitely for full coverage.

Test Plan:
1. Correct AND DUT, TRUTH=4'b1000, SETTLE=2; after start, drive 00, 01, 10, 11, each held 5 cycles -> cov=4'hF, done=1, pass=1, err_cnt=0, mismatch never pulses; first sample exactly 2 edges after start.
2. Faulty DUT with c stuck at 0, same sequence -> single mismatch pulse after the {1,1} sample, err_cnt=1, done=1, pass=0.
3. With b=0 and a idle at 0, pulse a high for 1 cycle (shorter than SETTLE=2), then hold 00 -> the {1,0} combination is not sampled and cov[2] stays 0.
4. CNT_W=2, c inverted, cycle through all four combinations twice by restarting coverage with re-sampled repeats -> err_cnt saturates at 3 and never wraps to 0.
5. Assert rst_n=0 mid-SETTLE after two samples -> all outputs return to reset values immediately (asynchronously); start then runs a clean full check to pass=1.
6. CHK_TIMEOUT_EN, TIMEOUT=50, drive only 00 and 01 -> timeout=1 and done=1 at the 50th busy cycle, pass=0, cov=4'b0011.
